// File: rtl/regfile_dbg_arbiter_pkg.sv
// Shared types and constants for the register-file debug arbiter.
package regfile_dbg_arbiter_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned DRAIN_CNT_W = 4;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = '0;
    localparam logic [XLEN-1:0]       ZERO_REG_DATA = '0;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ACCESS,
        RDATA,
        RESTORE
    } arb_state_e;

    // Register-file write port payload.
    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } rf_wr_t;

endpackage

// File: rtl/regfile_dbg_arbiter.sv
// Shares the regfile read/write ports between the pipeline and a debug requester.
// Idle passes the pipeline through; a debug request stalls, drains writebacks,
// performs one access and then restores the regfile's registered read addresses.
module regfile_dbg_arbiter
    import regfile_dbg_arbiter_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_rs_rd_en,
    input  logic [REG_ADDR_W-1:0] pipe_rs1,
    input  logic [REG_ADDR_W-1:0] pipe_rs2,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_rd_wr_data,
    input  logic                  pipe_rd_wr_en,
    output logic                  pipe_stall,
    output logic                  rs_rd_en,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       rd_wr_data,
    output logic                  rd_wr_en,
    input  logic [XLEN-1:0]       rs1_rd_data,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]       dbg_wdata,
    output logic                  dbg_ack,
    output logic [XLEN-1:0]       dbg_rdata
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    arb_state_e             state_q, state_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [REG_ADDR_W-1:0]  sv_rs1_q, sv_rs1_d;
    logic [REG_ADDR_W-1:0]  sv_rs2_q, sv_rs2_d;
    logic                   ack_d;
    logic [XLEN-1:0]        rdata_d;
    rf_wr_t                 wr_c;

    // State, drain counter, saved read addresses and registered debug outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            sv_rs1_q  <= ZERO_REG_ADDR;
            sv_rs2_q  <= ZERO_REG_ADDR;
            dbg_ack   <= 1'b0;
            dbg_rdata <= ZERO_REG_DATA;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            sv_rs1_q  <= sv_rs1_d;
            sv_rs2_q  <= sv_rs2_d;
            dbg_ack   <= ack_d;
            dbg_rdata <= rdata_d;
        end
    end

    // Next-state: drain countdown, one debug access, then a restore cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        sv_rs1_d = sv_rs1_q;
        sv_rs2_d = sv_rs2_q;
        ack_d    = 1'b0;
        rdata_d  = dbg_rdata;
        case (state_q)
            IDLE: begin
                if (pipe_rs_rd_en) begin
                    sv_rs1_d = pipe_rs1;
                    sv_rs2_d = pipe_rs2;
                end
                if (dbg_req) begin
                    cnt_d   = DRAIN_LOAD;
                    we_d    = dbg_we;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - DRAIN_CNT_W'(1);
                end
            end
            ACCESS: begin
                // A late writeback owns the write port; retry next cycle.
                if (!pipe_rd_wr_en) begin
                    if (we_q) begin
                        state_d = RESTORE;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = RDATA;
                    end
                end
            end
            RDATA: begin
                rdata_d = rs1_rd_data;
                ack_d   = 1'b1;
                state_d = RESTORE;
            end
            RESTORE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Port muxing toward regs; the pipeline owns the write port except for a debug write.
    always_comb begin
        rs_rd_en = 1'b0;
        rs1      = sv_rs1_q;
        rs2      = sv_rs2_q;
        wr_c     = '{en: pipe_rd_wr_en, addr: pipe_rd, data: pipe_rd_wr_data};
        case (state_q)
            IDLE: begin
                rs_rd_en = pipe_rs_rd_en;
                rs1      = pipe_rs1;
                rs2      = pipe_rs2;
            end
            ACCESS: begin
                if (!pipe_rd_wr_en) begin
                    if (we_q) begin
                        wr_c = '{en: 1'b1, addr: dbg_addr, data: dbg_wdata};
                    end else begin
                        rs_rd_en = 1'b1;
                        rs1      = dbg_addr;
                        rs2      = dbg_addr;
                    end
                end
            end
            RESTORE: rs_rd_en = 1'b1;
            default: ;
        endcase
    end

    assign pipe_stall = (state_q != IDLE);
    assign rd_wr_en   = wr_c.en;
    assign rd         = wr_c.addr;
    assign rd_wr_data = wr_c.data;

endmodule
